// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// Mode-0 (CPOL=0, CPHA=0) SPI responder that runs entirely in the sys_clk
// domain. SCLK, CS_N and MOSI are oversampled through synchroniser chains.
// MOSI is deserialised into DATA_W-bit words, and a reply word is serialised
// onto MISO. A one-word reply buffer decouples the host side from the link.
//
// The master's SCLK must be at most sys_clk/4. With SYNC_STAGES=2, MISO
// changes about 2.5 sys_clk cycles after the SCLK pin falls. A master running
// at sys_clk/4 must therefore sample MISO late in the high phase.
//
// Parameters
//   DATA_W       word width in bits, 2..32
//   SYNC_STAGES  synchroniser depth on each SPI input, >= 2
//   MSB_FIRST    1: MSB first on MOSI and MISO, 0: LSB first
//
// Ports
//   sys_clk    in   system clock; all state changes on its rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   spi_sclk   in   SPI clock from the master (asynchronous)
//   spi_cs_n   in   chip select, active low (asynchronous)
//   spi_mosi   in   master-out data (asynchronous)
//   spi_miso   out  slave-out data, registered; 0 outside a frame
//   tx_data    in   reply word to transmit
//   tx_valid   in   tx_data valid; accepted when tx_valid & tx_ready
//   tx_ready   out  reply buffer empty
//   rx_data    out  last completed received word, held until the next word
//   rx_valid   out  one-cycle pulse: rx_data has just been updated
//   frame_err  out  one-cycle pulse: CS deasserted mid-word
//   busy       out  high while a frame is active
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  // The CS chain presets to 1 (deselected). This prevents a false cs_fall
  // when reset is released.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample its
      // predecessor's old value, which is what makes this a shift register.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  // MOSI uses the same chain depth as SCLK, so the synced MOSI is the value
  // the pin held when the synced SCLK edge was sampled.
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign cs_rise   =  cs_s   & ~cs_dly_q;
  assign cs_fall   = ~cs_s   &  cs_dly_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q,  rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q,  tx_shift_d;
  logic [DATA_W-1:0]   rx_data_q,   rx_data_d;
  logic                rx_valid_q,  rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [DATA_W-1:0]   buf_q,       buf_d;
  logic                buf_full_q,  buf_full_d;
  logic                miso_q,      miso_d;
  logic                load_tx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      miso_q      <= miso_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default here first. A path
    // that skips an assignment would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    miso_d      = 1'b0;
    load_tx     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // SCLK edges are ignored until CS is asserted.
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          load_tx    = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (cs_rise) begin
          // CS release wins over an SCLK edge seen in the same cycle.
          // A partial word is dropped and reported.
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
        end else if (sclk_rise) begin
          if (MSB_FIRST != 0) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          end else begin
            rx_shift_d = {mosi_s, rx_shift_q[DATA_W-1:1]};
          end
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // A zero count on a falling edge means the previous word just
          // completed, so the next reply word starts here.
          if (bit_cnt_q == '0) begin
            load_tx = 1'b1;
          end else if (MSB_FIRST != 0) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Reply loading consumes the buffer if it is full. An empty buffer sends
    // zeros. The decision uses the registered buffer state, so a write in the
    // same cycle applies to the following word.
    if (load_tx) begin
      tx_shift_d = buf_full_q ? buf_q : '0;
      buf_full_d = 1'b0;
    end

    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    if (state_d == ST_ACTIVE) begin
      miso_d = (MSB_FIRST != 0) ? tx_shift_d[DATA_W-1] : tx_shift_d[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi_miso  = miso_q;
  assign tx_ready  = ~buf_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Instance A: DATA_W=8, MSB first.
// Instance B: DATA_W=16, LSB first.
// Both instances share SCLK and MOSI but each has its own chip select. Stimulus
// pushes expected received words and expected MISO words into queues. A monitor
// on the falling sys_clk edge pops them when the DUT pulses rx_valid or when
// the bench master finishes capturing a MISO word.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        cs_n_a;
  logic        cs_n_b;

  logic        miso_a;
  logic [7:0]  tx_data_a;
  logic        tx_valid_a;
  logic        tx_ready_a;
  logic [7:0]  rx_data_a;
  logic        rx_valid_a;
  logic        frame_err_a;
  logic        busy_a;

  logic        miso_b;
  logic [15:0] tx_data_b;
  logic        tx_valid_b;
  logic        tx_ready_b;
  logic [15:0] rx_data_b;
  logic        rx_valid_b;
  logic        frame_err_b;
  logic        busy_b;

  always #5 sys_clk = ~sys_clk;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1)) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (cs_n_a),
    .spi_mosi  (spi_mosi),
    .spi_miso  (miso_a),
    .tx_data   (tx_data_a),
    .tx_valid  (tx_valid_a),
    .tx_ready  (tx_ready_a),
    .rx_data   (rx_data_a),
    .rx_valid  (rx_valid_a),
    .frame_err (frame_err_a),
    .busy      (busy_a)
  );

  spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2), .MSB_FIRST(0)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (cs_n_b),
    .spi_mosi  (spi_mosi),
    .spi_miso  (miso_b),
    .tx_data   (tx_data_b),
    .tx_valid  (tx_valid_b),
    .tx_ready  (tx_ready_b),
    .rx_data   (rx_data_b),
    .rx_valid  (rx_valid_b),
    .frame_err (frame_err_b),
    .busy      (busy_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          sel    = 0;   // 0: instance A, 1: instance B
  logic [31:0] exp_rx_a_q[$];
  logic [31:0] exp_rx_b_q[$];
  logic [31:0] exp_miso_q[$];
  logic [31:0] obs_miso_q[$];
  int          exp_err_a  = 0;
  logic [31:0] last_rx_a  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (rx_valid_a) begin
        if (exp_rx_a_q.size() == 0) begin
          check("rx_valid_a unexpected", {31'd0, rx_valid_a}, 32'd0);
        end else begin
          last_rx_a = exp_rx_a_q.pop_front();
          check("rx_data_a", {24'd0, rx_data_a}, last_rx_a);
        end
      end
      if (frame_err_a) begin
        if (exp_err_a == 0) begin
          check("frame_err_a unexpected", {31'd0, frame_err_a}, 32'd0);
        end else begin
          exp_err_a--;
          check("rx_data_a held on frame_err", {24'd0, rx_data_a}, last_rx_a);
        end
        check("rx_valid_a with frame_err", {31'd0, rx_valid_a}, 32'd0);
      end
      if (rx_valid_b) begin
        if (exp_rx_b_q.size() == 0) begin
          check("rx_valid_b unexpected", {31'd0, rx_valid_b}, 32'd0);
        end else begin
          check("rx_data_b", {16'd0, rx_data_b}, exp_rx_b_q.pop_front());
        end
      end
      if (frame_err_b) begin
        check("frame_err_b unexpected", {31'd0, frame_err_b}, 32'd0);
      end
    end
    if (obs_miso_q.size() != 0) begin
      if (exp_miso_q.size() == 0) begin
        check("miso word unexpected", obs_miso_q.pop_front(), 32'hFFFF_FFFF);
      end else begin
        check("miso word", obs_miso_q.pop_front(), exp_miso_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bench SPI master
  // ---------------------------------------------------------------------------
  // Sends nbits of a w_bits-wide word. MOSI changes while SCLK is low. MISO is
  // sampled one sys_clk before each falling edge, which tolerates the DUT's
  // synchroniser latency even at sys_clk/4.
  task automatic spi_word(input int w_bits, input bit msb, input logic [31:0] word,
                          input int nbits, input int half, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx      = msb ? (w_bits - 1 - i) : i;
      spi_mosi = word[idx];
      wait_clks(half);
      spi_sclk = 1'b1;
      wait_clks(half - 1);
      got[idx] = (sel == 0) ? miso_a : miso_b;
      wait_clks(1);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_assert();
    if (sel == 0) cs_n_a = 1'b0;
    else          cs_n_b = 1'b0;
    wait_clks(6);
  endtask

  task automatic cs_release();
    wait_clks(4);
    if (sel == 0) cs_n_a = 1'b1;
    else          cs_n_b = 1'b1;
    wait_clks(8);
  endtask

  task automatic tx_write(input logic [15:0] data);
    int t;
    t = 0;
    while (((sel == 0) ? tx_ready_a : tx_ready_b) !== 1'b1 && t < 200) begin
      wait_clks(1);
      t++;
    end
    if (t >= 200) check("tx_ready timeout", {31'd0, (sel == 0) ? tx_ready_a : tx_ready_b}, 32'd1);
    if (sel == 0) begin
      tx_data_a  = data[7:0];
      tx_valid_a = 1'b1;
    end else begin
      tx_data_b  = data;
      tx_valid_b = 1'b1;
    end
    wait_clks(1);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " spi_miso"},  {31'd0, miso_a},      32'd0);
    check({tag, " rx_data"},   {24'd0, rx_data_a},   32'd0);
    check({tag, " rx_valid"},  {31'd0, rx_valid_a},  32'd0);
    check({tag, " frame_err"}, {31'd0, frame_err_a}, 32'd0);
    check({tag, " busy"},      {31'd0, busy_a},      32'd0);
    check({tag, " tx_ready"},  {31'd0, tx_ready_a},  32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] got;
  logic [7:0]  rnd_w[16];
  logic [7:0]  rnd_r[16];

  initial begin
    sys_rst_n  = 1'b0;
    spi_sclk   = 1'b0;
    spi_mosi   = 1'b0;
    cs_n_a     = 1'b1;
    cs_n_b     = 1'b1;
    tx_data_a  = '0;
    tx_valid_a = 1'b0;
    tx_data_b  = '0;
    tx_valid_b = 1'b0;
    wait_clks(3);
    check_reset_a("reset");
    check("reset tx_ready_b", {31'd0, tx_ready_b}, 32'd1);
    sys_rst_n = 1'b1;
    wait_clks(4);

    // 1: single word 0xA5 in, reply 0x3C out.
    sel = 0;
    tx_write(16'h3C);
    check("tx_ready after write", {31'd0, tx_ready_a}, 32'd0);
    exp_rx_a_q.push_back(32'hA5);
    exp_miso_q.push_back(32'h3C);
    cs_assert();
    check("busy in frame", {31'd0, busy_a}, 32'd1);
    check("tx_ready after load", {31'd0, tx_ready_a}, 32'd1);
    spi_word(8, 1'b1, 32'hA5, 8, 4, got);
    obs_miso_q.push_back(got);
    cs_release();
    check("busy after frame", {31'd0, busy_a}, 32'd0);

    // 2: three back-to-back words. The second reply is written during word 1,
    // and the third word underruns.
    tx_write(16'h11);
    exp_rx_a_q.push_back(32'h01);
    exp_rx_a_q.push_back(32'h80);
    exp_rx_a_q.push_back(32'hFF);
    exp_miso_q.push_back(32'h11);
    exp_miso_q.push_back(32'h22);
    exp_miso_q.push_back(32'h00);
    cs_assert();
    fork
      tx_write(16'h22);
      begin
        logic [31:0] g;
        spi_word(8, 1'b1, 32'h01, 8, 4, g); obs_miso_q.push_back(g);
        spi_word(8, 1'b1, 32'h80, 8, 4, g); obs_miso_q.push_back(g);
        spi_word(8, 1'b1, 32'hFF, 8, 4, g); obs_miso_q.push_back(g);
      end
    join
    cs_release();

    // 3: CS raised after 5 bits, then a clean 0x5A frame.
    exp_err_a++;
    cs_assert();
    spi_word(8, 1'b1, 32'hB7, 5, 4, got);
    cs_release();
    check("frame_err consumed", exp_err_a, 32'd0);
    tx_write(16'h96);
    exp_rx_a_q.push_back(32'h5A);
    exp_miso_q.push_back(32'h96);
    cs_assert();
    spi_word(8, 1'b1, 32'h5A, 8, 4, got);
    obs_miso_q.push_back(got);
    cs_release();

    // 4: reset after 3 bits of a word, then a full 0xC3 frame.
    cs_assert();
    spi_word(8, 1'b1, 32'hE1, 3, 4, got);
    sys_rst_n = 1'b0;
    wait_clks(2);
    check_reset_a("mid-frame reset");
    cs_n_a   = 1'b1;
    last_rx_a = '0;
    wait_clks(2);
    sys_rst_n = 1'b1;
    wait_clks(4);
    check("rx_data after reset", {24'd0, rx_data_a}, 32'd0);
    tx_write(16'h4B);
    exp_rx_a_q.push_back(32'hC3);
    exp_miso_q.push_back(32'h4B);
    cs_assert();
    spi_word(8, 1'b1, 32'hC3, 8, 4, got);
    obs_miso_q.push_back(got);
    cs_release();

    // 5: 16 random words at sys_clk/4 in one frame. Replies are kept one word ahead.
    for (int k = 0; k < 16; k++) begin
      rnd_w[k] = 8'($urandom_range(0, 255));
      rnd_r[k] = 8'($urandom_range(0, 255));
      exp_rx_a_q.push_back({24'd0, rnd_w[k]});
      exp_miso_q.push_back({24'd0, rnd_r[k]});
    end
    tx_write({8'd0, rnd_r[0]});
    cs_assert();
    fork
      for (int k = 1; k < 16; k++) tx_write({8'd0, rnd_r[k]});
      for (int k = 0; k < 16; k++) begin
        logic [31:0] g;
        spi_word(8, 1'b1, {24'd0, rnd_w[k]}, 8, 2, g);
        obs_miso_q.push_back(g);
      end
    join
    cs_release();

    // 6: 16-bit LSB-first instance, 0x1234 in, reply 0xBEEF.
    sel = 1;
    tx_write(16'hBEEF);
    exp_rx_b_q.push_back(32'h1234);
    exp_miso_q.push_back(32'hBEEF);
    cs_assert();
    spi_word(16, 1'b0, 32'h1234, 16, 4, got);
    obs_miso_q.push_back(got);
    cs_release();

    for (int i = 0; i < 400 && (exp_rx_a_q.size() != 0 || exp_rx_b_q.size() != 0 ||
                                obs_miso_q.size() != 0); i++) begin
      wait_clks(1);
    end
    check("pending rx_a words", exp_rx_a_q.size(), 32'd0);
    check("pending rx_b words", exp_rx_b_q.size(), 32'd0);
    check("pending miso words", exp_miso_q.size(), 32'd0);
    check("pending frame_err", exp_err_a, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
